// File: rtl/commodity_pkg.sv
// Shared commodity pricing constants: price table, sum widths and the
// subset-finder state encoding used by the pricing and inverse-pricing paths.
package commodity_pkg;

   localparam int PRICE_W    = 5;
   localparam int SUM_W      = 6;
   localparam int NUM_PRICES = 6;

   // Entry 0 is the rightmost element of the concatenation.
   localparam logic [NUM_PRICES-1:0][PRICE_W-1:0] PRICE_TABLE =
      {5'd5, 5'd4, 5'd10, 5'd3, 5'd8, 5'd2};

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      DONE   = 2'd2
   } state_t;

   function automatic logic [SUM_W-1:0] PRICE_TOTAL(input int n);
      logic [SUM_W-1:0] total;
      total = {SUM_W{1'b0}};
      for (int i = 0; i < NUM_PRICES; i++) begin
         if (i < n) begin
            total = total + SUM_W'(PRICE_TABLE[i]);
         end else begin
            total = total;
         end
      end
      return total;
   endfunction

endpackage

// File: rtl/commodity_price_sum.sv
// Combinational total of the table prices selected by a commodity mask.
module commodity_price_sum
   import commodity_pkg::*;
#(
   parameter int N = 6
) (
   input  logic [N-1:0]     mask,
   output logic [SUM_W-1:0] sum
);

   // Add the price of every selected commodity; the full table fits SUM_W.
   always_comb begin
      sum = {SUM_W{1'b0}};
      for (int j = 0; j < N; j++) begin
         if (mask[j]) begin
            sum = sum + SUM_W'(PRICE_TABLE[j]);
         end else begin
            sum = sum;
         end
      end
   end

endmodule

// File: rtl/commodity_subset_finder.sv
// Searches commodity masks in ascending order for the first whose price
// total equals the requested target; one candidate evaluated per cycle.
module commodity_subset_finder
   import commodity_pkg::*;
#(
   parameter int N = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [5:0]       target,
   output logic             busy,
   output logic             done,
   output logic             found,
   output logic [N-1:0]     mask
);

   localparam logic [SUM_W-1:0] TOTAL_PRICE = PRICE_TOTAL(N);
   localparam logic [N-1:0]     CAND_MAX    = {N{1'b1}};
   localparam logic [N-1:0]     CAND_ONE    = N'(1'b1);

   state_t           state_r;
   logic [N-1:0]     cand_r;
   logic [SUM_W-1:0] target_r;
   logic             reject_r;
   logic [SUM_W-1:0] sum_s;

   commodity_price_sum #(.N(N)) u_price_sum (
      .mask (cand_r),
      .sum  (sum_s)
   );

   // Search FSM with candidate counter, latched target and registered results.
   // An over-total target spends one idle cycle in reject_r so the reject
   // result lands one cycle after the start edge without raising busy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         cand_r   <= {N{1'b0}};
         target_r <= {SUM_W{1'b0}};
         reject_r <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         found    <= 1'b0;
         mask     <= {N{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (reject_r) begin
                  reject_r <= 1'b0;
                  state_r  <= DONE;
                  done     <= 1'b1;
                  found    <= 1'b0;
                  mask     <= {N{1'b0}};
               end else if (start) begin
                  if (target > TOTAL_PRICE) begin
                     reject_r <= 1'b1;
                  end else begin
                     target_r <= target;
                     cand_r   <= {N{1'b0}};
                     busy     <= 1'b1;
                     state_r  <= SEARCH;
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            SEARCH: begin
               if (sum_s == target_r) begin
                  state_r <= DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  found   <= 1'b1;
                  mask    <= cand_r;
               end else if (cand_r == CAND_MAX) begin
                  state_r <= DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  found   <= 1'b0;
                  mask    <= {N{1'b0}};
               end else begin
                  cand_r <= cand_r + CAND_ONE;
               end
            end
            DONE: begin
               state_r <= IDLE;
               done    <= 1'b0;
            end
            default: begin
               state_r  <= IDLE;
               reject_r <= 1'b0;
               busy     <= 1'b0;
               done     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_commodity_subset_finder.sv
// Directed and randomized checks of commodity_subset_finder against an
// independent search model built from the plain price list.
module tb_commodity_subset_finder;

   localparam int N = 6;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [5:0]   target = 6'd0;
   logic         busy;
   logic         done;
   logic         found;
   logic [N-1:0] mask;

   int errors = 0;
   int checks = 0;

   int prices [6] = '{2, 8, 3, 10, 4, 5};

   commodity_subset_finder #(.N(N)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .target (target),
      .busy   (busy),
      .done   (done),
      .found  (found),
      .mask   (mask)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: brute-force subset search over the price list.
   task automatic model(input int t, output logic f, output int m, output int lat);
      int total;
      total = 0;
      for (int j = 0; j < N; j++) total += prices[j];
      f = 1'b0; m = 0; lat = 1 << N;
      if (t > total) begin
         lat = 1;
         return;
      end
      for (int c = 0; c < (1 << N); c++) begin
         int s;
         s = 0;
         for (int j = 0; j < N; j++) if (c[j]) s += prices[j];
         if (s == t) begin
            f = 1'b1; m = c; lat = c + 1;
            return;
         end
      end
   endtask

   task automatic do_search(input int t, input int inject_at, output logic f,
                            output int m, output int lat, output logic busy_seen);
      @(negedge clk);
      start = 1'b1;
      target = 6'(t);
      @(posedge clk);
      #1;
      start = 1'b0;
      target = 6'($urandom_range(0, 63));
      busy_seen = 1'b0;
      lat = 0; f = 1'b0; m = 0;
      while (lat < 200) begin
         if (inject_at > 0 && lat == inject_at) begin
            start = 1'b1;
            target = 6'd2;
         end
         @(posedge clk);
         #1;
         start = 1'b0;
         lat++;
         if (done) begin
            f = found;
            m = 32'(mask);
            break;
         end
         busy_seen |= busy;
      end
   endtask

   task automatic run_check(input string tag, input int t, input int inject_at);
      logic f, ef, bs;
      int m, em, lat, elat;
      model(t, ef, em, elat);
      do_search(t, inject_at, f, m, lat, bs);
      chk({tag, ".found"}, 32'(f), 32'(ef));
      chk({tag, ".mask"}, 32'(m), 32'(em));
      chk({tag, ".latency"}, 32'(lat), 32'(elat));
      chk({tag, ".busy_seen"}, 32'(bs), 32'(t <= 32 && elat > 1));
      @(posedge clk);
      #1;
      chk({tag, ".done_one_cycle"}, 32'(done), 32'd0);
      chk({tag, ".found_hold"}, 32'(found), 32'(ef));
      chk({tag, ".mask_hold"}, 32'(mask), 32'(em));
   endtask

   initial begin
      int pulses;
      // Reset then idle.
      #2;
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.done", 32'(done), 32'd0);
      chk("rst.found", 32'(found), 32'd0);
      chk("rst.mask", 32'(mask), 32'd0);
      #20;
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (done) pulses++;
      end
      chk("idle.no_done", 32'(pulses), 32'd0);
      chk("idle.busy", 32'(busy), 32'd0);

      run_check("t2", 2, 0);
      run_check("t5", 5, 0);
      run_check("t0", 0, 0);
      run_check("t32", 32, 0);
      run_check("t1", 1, 0);
      run_check("t31", 31, 0);
      run_check("t40", 40, 0);
      run_check("t32_inject", 32, 10);

      for (int k = 0; k < 12; k++) begin
         run_check("rand", int'($urandom_range(0, 40)), 0);
      end

      // Leave found/mask nonzero, then abort a search with reset.
      run_check("pre_abort", 32, 0);
      @(negedge clk);
      start = 1'b1;
      target = 6'd1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int i = 0; i < 19; i++) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("abort.busy", 32'(busy), 32'd0);
      chk("abort.done", 32'(done), 32'd0);
      chk("abort.found", 32'(found), 32'd0);
      chk("abort.mask", 32'(mask), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 70; i++) begin
         @(posedge clk);
         #1;
         if (done) pulses++;
      end
      chk("abort.no_done", 32'(pulses), 32'd0);
      run_check("t13", 13, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
